// File: rtl/fixed_power_if.sv
// Request/result bundle for the fixed_power exponentiation unit.
// The master drives requests and the slave (the power unit) returns results.
interface fixed_power_if #(
  parameter int DATA_W = 20
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data_1;
  logic [2:0]        in_data_2;
  logic              busy;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf;

  modport master (
    output in_valid, in_data_1, in_data_2,
    input  busy, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data_1, in_data_2,
    output busy, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/fixed_power.sv
// Iterative unsigned Q10.10 base^n (n = 0..7), one multiply per clock.
// Define FIXED_POWER_SATURATE_EN to clamp the result to all-ones after an overflow.
//
// state | meaning
// IDLE  | waiting for in_valid; latches base/n and seeds acc with 1.0
// MUL   | one truncating multiply per cycle, n cycles in total
// OUT   | loads the one-cycle result registers, then back to IDLE
module fixed_power #(
  parameter int FRAC_BITS = 10,
  parameter int DATA_W    = 20
) (
  input  logic        clk,
  input  logic        rst,
  fixed_power_if.slave bus
);
  localparam int PW = 2 * DATA_W;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] base_q;
  logic [2:0]        n_q;
  logic [DATA_W-1:0] acc_q;
  logic [2:0]        cnt_q;
  logic              ovf_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_ovf_q;

  logic [PW-1:0]     prod;
  logic [PW-1:0]     prod_sh;
  logic              prod_ovf;
  logic [DATA_W-1:0] acc_next;

  assign prod     = PW'(acc_q) * PW'(base_q);
  assign prod_sh  = prod >> FRAC_BITS;
  // Anything above the integer field of the result is lost precision.
  assign prod_ovf = |prod_sh[PW-1:DATA_W];

`ifdef FIXED_POWER_SATURATE_EN
  assign acc_next = (ovf_q | prod_ovf) ? '1 : prod_sh[DATA_W-1:0];
`else
  assign acc_next = prod_sh[DATA_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = (bus.in_data_2 != 3'd0) ? MUL : OUT;
        end
      end
      MUL: begin
        if (cnt_q == n_q - 3'd1) begin
          state_d = OUT;
        end
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= '0;
      n_q         <= '0;
      acc_q       <= ONE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            base_q <= bus.in_data_1;
            n_q    <= bus.in_data_2;
            acc_q  <= ONE;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
          end
        end
        MUL: begin
          acc_q <= acc_next;
          ovf_q <= ovf_q | prod_ovf;
          cnt_q <= cnt_q + 3'd1;
        end
        OUT: begin
          out_valid_q <= 1'b1;
          out_data_q  <= acc_q;
          out_ovf_q   <= ovf_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_fixed_power.sv
// Directed bench for fixed_power: a vector table plus hand-written
// sequences for busy-ignore, back-to-back and mid-operation reset.
module tb_fixed_power;
  logic clk;
  logic rst;

  fixed_power_if #(.DATA_W(20)) bus ();

  fixed_power #(.FRAC_BITS(10), .DATA_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FIXED_POWER_SATURATE_EN
  localparam logic [19:0] EXP_4_POW_7  = 20'hFFFFF;
  localparam logic [19:0] EXP_MAX_SQ   = 20'hFFFFF;
`else
  localparam logic [19:0] EXP_4_POW_7  = 20'h00000;
  localparam logic [19:0] EXP_MAX_SQ   = 20'hFF800;
`endif

  typedef struct {
    logic [19:0] base;
    logic [2:0]  n;
    logic [19:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [11];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where out_valid is seen.
  task automatic run_op(input logic [19:0] base, input logic [2:0] n,
                        input logic [19:0] ed, input logic eo, input string tag);
    int lat;
    bus.in_valid  = 1'b1;
    bus.in_data_1 = base;
    bus.in_data_2 = n;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_data_1 = 20'h5A5A5;
    bus.in_data_2 = 3'd5;
    check({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(n) + 32'd1);
    check({tag, " data"}, 32'(bus.out_data), 32'(ed));
    check({tag, " ovf"}, 32'(bus.out_ovf), 32'(eo));
    check({tag, " busy_at_out"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
  endtask

  initial begin
    int seen;
    int lat;

    vecs[0]  = '{20'h00600, 3'd2, 20'h00900, 1'b0};
    vecs[1]  = '{20'h00000, 3'd0, 20'h00400, 1'b0};
    vecs[2]  = '{20'h00800, 3'd7, 20'h20000, 1'b0};
    vecs[3]  = '{20'h00401, 3'd2, 20'h00402, 1'b0};
    vecs[4]  = '{20'h01000, 3'd7, EXP_4_POW_7, 1'b1};
    vecs[5]  = '{20'h12345, 3'd1, 20'h12345, 1'b0};
    vecs[6]  = '{20'h00000, 3'd3, 20'h00000, 1'b0};
    vecs[7]  = '{20'hABCDE, 3'd0, 20'h00400, 1'b0};
    vecs[8]  = '{20'h01000, 3'd4, 20'h40000, 1'b0};
    vecs[9]  = '{20'hFFFFF, 3'd2, EXP_MAX_SQ, 1'b1};
    vecs[10] = '{20'h00200, 3'd3, 20'h00080, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data_1 = '0;
    bus.in_data_2 = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_data", 32'(bus.out_data), 32'd0);
    check("reset out_ovf", 32'(bus.out_ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 11; v++) begin
      run_op(vecs[v].base, vecs[v].n, vecs[v].exp_data, vecs[v].exp_ovf,
             $sformatf("vec%0d", v));
      @(negedge clk);
      check($sformatf("vec%0d out_valid_one_cycle", v), 32'(bus.out_valid), 32'd0);
      check($sformatf("vec%0d out_data_idle_zero", v), 32'(bus.out_data), 32'd0);
    end

    // Second request while busy must be ignored.
    bus.in_valid  = 1'b1;
    bus.in_data_1 = 20'h00600;
    bus.in_data_2 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    bus.in_data_1 = 20'h00800;
    bus.in_data_2 = 3'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ignore latency", 32'(lat), 32'd3);
    check("ignore data", 32'(bus.out_data), 32'h00900);
    count_valid(12, seen);
    check("ignore no_second_result", 32'(seen), 32'd0);

    // Back-to-back: the second request arrives in the out_valid cycle.
    run_op(20'h00800, 3'd3, 20'h02000, 1'b0, "b2b_first");
    run_op(20'h00600, 3'd2, 20'h00900, 1'b0, "b2b_second");
    @(negedge clk);
    check("b2b out_valid_one_cycle", 32'(bus.out_valid), 32'd0);

    // Reset during MUL aborts with no result.
    bus.in_valid  = 1'b1;
    bus.in_data_1 = 20'h00800;
    bus.in_data_2 = 3'd7;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort out_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_valid(12, seen);
    check("abort no_result", 32'(seen), 32'd0);
    @(negedge clk);
    run_op(20'h00600, 3'd2, 20'h00900, 1'b0, "post_rst");
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
